player_move_ctrl: RTL
=====================

PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

Interface
REQ-001 Parameters SHALL be: STEP default 4, pixels moved per frame; SPRITE default 16, square sprite size in px; H_MAX default 640, visible width; V_MAX default 480, visible height.
REQ-002 Parameters SHALL include start positions: P1_X0 default 80, P1_Y0 default 232, P2_X0 default 544, P2_Y0 default 232.
REQ-003 Master_Clock_In  in  1  single clock for all logic (25 MHz pixel clock domain).
REQ-004 Reset_N_In  in  1  reset, synchronous, active-high.
REQ-005 Frame_Tick_In  in  1  one-cycle pulse at start of vertical blank.
REQ-006 P1_Keys_In  in  4  player 1 {Up,Down,Left,Right}, level, already synchronous.
REQ-007 P2_Keys_In  in  4  player 2 {Up,Down,Left,Right}, same encoding.
REQ-008 P1_X_Out, P1_Y_Out, P2_X_Out, P2_Y_Out  out  10 each  committed sprite top-left corners, registered.
REQ-009 Busy_Out  out  1  high while the FSM is not IDLE.
REQ-010 Update_Done_Out  out  1  one-cycle pulse in the cycle after positions commit.
REQ-011 Collide_Out  out  1  one-cycle pulse, coincident with Update_Done_Out, when any move was reverted.

Function
REQ-012 FSM states SHALL be IDLE, CALC_A, CALC_B, CHECK, COMMIT; each non-IDLE state lasts exactly one cycle.
REQ-013 In IDLE, Frame_Tick_In high SHALL latch both key vectors and current positions, then go to CALC_A; Frame_Tick_In high outside IDLE SHALL be ignored.
REQ-014 Priority bit SHALL select which player is first (A): 0 = P1 first, 1 = P2 first; it toggles in COMMIT every frame.
REQ-015 CALC_A and CALC_B SHALL compute the candidate position of the first and second player respectively.
REQ-016 Candidate X SHALL be old X - STEP on Left and + STEP on Right; Y SHALL be old Y - STEP on Up and + STEP on Down; Left+Right together, or Up+Down together, SHALL cancel on that axis.
REQ-017 Candidate arithmetic SHALL use an 11-bit signed intermediate; results below 0 SHALL clamp to 0; results above H_MAX-SPRITE (X) or V_MAX-SPRITE (Y) SHALL clamp to that limit.
REQ-018 Two boxes SHALL overlap when |xa-xb| < SPRITE and |ya-yb| < SPRITE.
REQ-019 In CHECK, if candidate A overlaps candidate B, B SHALL revert to its latched old position.
REQ-020 In CHECK, if candidate A then overlaps B's final position, A SHALL also revert.
REQ-021 Any revert in CHECK SHALL set the collide flag for this frame.
REQ-022 COMMIT SHALL update all four position outputs on the same edge, so no half-updated pair is ever visible; then return to IDLE.
REQ-023 Latency: with the tick sampled at edge N, positions SHALL change at edge N+4 and Update_Done_Out SHALL be high during the cycle following N+4.
REQ-024 With no keys pressed, positions SHALL be unchanged, and Update_Done_Out SHALL still pulse.

Reset
REQ-025 Reset_N_In high SHALL, at the next edge, force IDLE and priority 0.
REQ-026 Reset SHALL load P1_X0/P1_Y0/P2_X0/P2_Y0 onto the position outputs and clear Busy_Out, Update_Done_Out and Collide_Out.
REQ-027 Reset mid-frame SHALL discard the in-flight update, with no commit and no Update_Done_Out pulse.
REQ-028 Reset SHALL dominate a simultaneous Frame_Tick_In.

Configuration
REQ-029 Macro COLLISION_EN defined: CHECK state, overlap logic and Collide_Out behave per REQ-018..021; latency is N+4.
REQ-030 Macro COLLISION_EN undefined: CHECK SHALL be omitted, so CALC_B goes directly to COMMIT, positions change at edge N+3, and Collide_Out is tied 0.

Verification
REQ-031 Reset, then one tick with P1=Right, P2=Left -> P1=(84,232), P2=(540,232), Update_Done_Out pulse 4 cycles after the tick, Collide_Out=0.
REQ-032 P1 at (0,0) with Left+Up held for 3 frames -> stays (0,0); P2 at (620,460) with Right+Down held -> clamps at (624,464).
REQ-033 P1 at (100,100), P2 at (120,100); P1=Right, P2=Left, priority 0 -> P1=(104,100), P2 stays (120,100), Collide_Out=1; repeated with priority 1 -> P2=(116,100), P1 stays (100,100).
REQ-034 Ticks at N and N+2 -> only one update is committed and Busy_Out is high from N+1 to N+4; Left+Right held together -> X unchanged.
REQ-035 Reset asserted at N+2 after a tick -> no Update_Done_Out pulse, positions return to the start values, next tick processed normally with priority 0.
REQ-036 Build without COLLISION_EN, repeating the REQ-033 overlap stimulus -> both players move, Collide_Out=0, latency 3 cycles.

Source files
------------

// File: rtl/player_move_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// player_move_ctrl
//
// Purpose:
//   Moves two square sprites once per video frame. At each frame tick it
//   computes both players' candidate positions in turn, clamps them to the
//   visible area, optionally resolves collisions, and then commits all four
//   coordinates together.
//
// Configuration:
//   COLLISION_EN  (define to enable) adds the CHECK state: the second
//                 player's move is undone if it overlaps the first player's
//                 candidate. The first player's move is then undone if it
//                 still overlaps, and Collide_Out pulses. Without it, CALC_B
//                 goes straight to COMMIT and Collide_Out is tied low.
//
// Ports:
//   Master_Clock_In   single clock for all logic
//   Reset_N_In        synchronous reset, active HIGH despite the name
//   Frame_Tick_In     one-cycle pulse at start of vertical blank
//   P1_Keys_In[3:0]   player 1 keys {Up,Down,Left,Right}, level
//   P2_Keys_In[3:0]   player 2 keys, same encoding
//   P1_X_Out/P1_Y_Out committed player 1 top-left corner (registered)
//   P2_X_Out/P2_Y_Out committed player 2 top-left corner (registered)
//   Busy_Out          high while the FSM is not IDLE
//   Update_Done_Out   one-cycle pulse in the cycle after positions commit
//   Collide_Out       pulse alongside Update_Done_Out when a move was undone
// -----------------------------------------------------------------------------
module player_move_ctrl #(
  parameter int STEP   = 4,
  parameter int SPRITE = 16,
  parameter int H_MAX  = 640,
  parameter int V_MAX  = 480,
  parameter int P1_X0  = 80,
  parameter int P1_Y0  = 232,
  parameter int P2_X0  = 544,
  parameter int P2_Y0  = 232
) (
  input  logic       Master_Clock_In,
  input  logic       Reset_N_In,
  input  logic       Frame_Tick_In,
  input  logic [3:0] P1_Keys_In,
  input  logic [3:0] P2_Keys_In,
  output logic [9:0] P1_X_Out,
  output logic [9:0] P1_Y_Out,
  output logic [9:0] P2_X_Out,
  output logic [9:0] P2_Y_Out,
  output logic       Busy_Out,
  output logic       Update_Done_Out,
  output logic       Collide_Out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CALC_A = 3'd1;
  localparam logic [2:0] S_CALC_B = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] X_LIM  = 11'(H_MAX - SPRITE);
  localparam logic signed [10:0] Y_LIM  = 11'(V_MAX - SPRITE);

  // One axis step: the signed intermediate lets "0 - STEP" go negative so it
  // can be clamped instead of wrapping. Opposite keys cancel.
  function automatic logic [9:0] move_axis(input logic [9:0]        pos,
                                           input logic              dec,
                                           input logic              inc,
                                           input logic signed [10:0] lim);
    logic signed [10:0] v;
    v = $signed({1'b0, pos});
    if (dec && !inc)
      v = v - STEP_S;
    else if (inc && !dec)
      v = v + STEP_S;
    if (v < 11'sd0)
      v = 11'sd0;
    else if (v > lim)
      v = lim;
    return v[9:0];
  endfunction

  logic [2:0] state_reg, state_next;
  logic       prio_reg;          // 0: player 1 is A, 1: player 2 is A
  logic [3:0] keys_a_reg, keys_b_reg;
  logic [9:0] old_ax_reg, old_ay_reg, old_bx_reg, old_by_reg;
  logic [9:0] cand_ax_reg, cand_ay_reg, cand_bx_reg, cand_by_reg;
  logic [9:0] p1_x_reg, p1_y_reg, p2_x_reg, p2_y_reg;
  logic       done_reg;

  // Shared candidate calculator: serves player A in CALC_A and B in CALC_B.
  logic [3:0] cur_keys;
  logic [9:0] cur_pos   [2];
  logic [9:0] cand_next [2];

  assign cur_keys   = (state_reg == S_CALC_B) ? keys_b_reg : keys_a_reg;
  assign cur_pos[0] = (state_reg == S_CALC_B) ? old_bx_reg : old_ax_reg;
  assign cur_pos[1] = (state_reg == S_CALC_B) ? old_by_reg : old_ay_reg;

  // Axis 0 is X (dec=Left bit1, inc=Right bit0); axis 1 is Y (dec=Up bit3,
  // inc=Down bit2).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      assign cand_next[gi] = move_axis(cur_pos[gi],
                                       cur_keys[2*gi+1],
                                       cur_keys[2*gi],
                                       (gi == 0) ? X_LIM : Y_LIM);
    end
  endgenerate

`ifdef COLLISION_EN
  localparam logic [9:0] SPRITE_U = 10'(SPRITE);

  function automatic logic overlap(input logic [9:0] ax, input logic [9:0] ay,
                                   input logic [9:0] bx, input logic [9:0] by);
    logic [9:0] dx, dy;
    dx = (ax > bx) ? (ax - bx) : (bx - ax);
    dy = (ay > by) ? (ay - by) : (by - ay);
    return (dx < SPRITE_U) && (dy < SPRITE_U);
  endfunction

  logic       hit_reg, collide_reg;
  logic       revert_b, revert_a;
  logic [9:0] fin_ax, fin_ay, fin_bx, fin_by;

  // B yields first; A is then tested against wherever B ended up.
  always_comb begin
    revert_b = overlap(cand_ax_reg, cand_ay_reg, cand_bx_reg, cand_by_reg);
    fin_bx   = revert_b ? old_bx_reg : cand_bx_reg;
    fin_by   = revert_b ? old_by_reg : cand_by_reg;
    revert_a = overlap(cand_ax_reg, cand_ay_reg, fin_bx, fin_by);
    fin_ax   = revert_a ? old_ax_reg : cand_ax_reg;
    fin_ay   = revert_a ? old_ay_reg : cand_ay_reg;
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (Frame_Tick_In) state_next = S_CALC_A;
      S_CALC_A: state_next = S_CALC_B;
`ifdef COLLISION_EN
      S_CALC_B: state_next = S_CHECK;
      S_CHECK:  state_next = S_COMMIT;
`else
      S_CALC_B: state_next = S_COMMIT;
`endif
      S_COMMIT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Master_Clock_In) begin
    if (Reset_N_In) begin
      state_reg   <= S_IDLE;
      prio_reg    <= 1'b0;
      keys_a_reg  <= '0;
      keys_b_reg  <= '0;
      old_ax_reg  <= '0;
      old_ay_reg  <= '0;
      old_bx_reg  <= '0;
      old_by_reg  <= '0;
      cand_ax_reg <= '0;
      cand_ay_reg <= '0;
      cand_bx_reg <= '0;
      cand_by_reg <= '0;
      p1_x_reg    <= 10'(P1_X0);
      p1_y_reg    <= 10'(P1_Y0);
      p2_x_reg    <= 10'(P2_X0);
      p2_y_reg    <= 10'(P2_Y0);
      done_reg    <= 1'b0;
`ifdef COLLISION_EN
      hit_reg     <= 1'b0;
      collide_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
`ifdef COLLISION_EN
      collide_reg <= 1'b0;
`endif
      case (state_reg)
        S_IDLE: begin
          if (Frame_Tick_In) begin
            keys_a_reg <= prio_reg ? P2_Keys_In : P1_Keys_In;
            keys_b_reg <= prio_reg ? P1_Keys_In : P2_Keys_In;
            old_ax_reg <= prio_reg ? p2_x_reg : p1_x_reg;
            old_ay_reg <= prio_reg ? p2_y_reg : p1_y_reg;
            old_bx_reg <= prio_reg ? p1_x_reg : p2_x_reg;
            old_by_reg <= prio_reg ? p1_y_reg : p2_y_reg;
`ifdef COLLISION_EN
            hit_reg    <= 1'b0;
`endif
          end
        end
        S_CALC_A: begin
          cand_ax_reg <= cand_next[0];
          cand_ay_reg <= cand_next[1];
        end
        S_CALC_B: begin
          cand_bx_reg <= cand_next[0];
          cand_by_reg <= cand_next[1];
        end
`ifdef COLLISION_EN
        S_CHECK: begin
          cand_ax_reg <= fin_ax;
          cand_ay_reg <= fin_ay;
          cand_bx_reg <= fin_bx;
          cand_by_reg <= fin_by;
          hit_reg     <= revert_a | revert_b;
        end
`endif
        S_COMMIT: begin
          // All four coordinates change on this single edge.
          if (prio_reg) begin
            p2_x_reg <= cand_ax_reg;
            p2_y_reg <= cand_ay_reg;
            p1_x_reg <= cand_bx_reg;
            p1_y_reg <= cand_by_reg;
          end else begin
            p1_x_reg <= cand_ax_reg;
            p1_y_reg <= cand_ay_reg;
            p2_x_reg <= cand_bx_reg;
            p2_y_reg <= cand_by_reg;
          end
          prio_reg <= ~prio_reg;
          done_reg <= 1'b1;
`ifdef COLLISION_EN
          collide_reg <= hit_reg;
`endif
        end
        default: ;
      endcase
    end
  end

  assign P1_X_Out        = p1_x_reg;
  assign P1_Y_Out        = p1_y_reg;
  assign P2_X_Out        = p2_x_reg;
  assign P2_Y_Out        = p2_y_reg;
  assign Busy_Out        = (state_reg != S_IDLE);
  assign Update_Done_Out = done_reg;
`ifdef COLLISION_EN
  assign Collide_Out     = collide_reg;
`else
  assign Collide_Out     = 1'b0;
`endif

endmodule
